// File: rtl/sram_mem_controller.sv
// Sequences a 16-bit external SRAM for the MEM stage: each 32-bit load/store
// becomes two half-word accesses (low half first) while ready holds the pipeline.
module sram_mem_controller #(
  parameter int SRAM_AW     = 18,
  parameter int BASE_ADDR   = 1024,
  parameter int HALF_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int WORD_W = SRAM_AW - 1;
  localparam int CNT_W  = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  word_q;
  logic [31:0]        wdata_q;
  logic               op_wr_q;
  logic [31:0]        offset;
  logic               req;
  logic               cnt_last;
  logic               unused_offset_bits;

  assign req      = rd_en | wr_en;
  assign cnt_last = (cnt == CNT_LAST);
  assign offset   = address - 32'(BASE_ADDR);
  // Bits above the SRAM window are dropped so out-of-range addresses wrap.
  assign unused_offset_bits = ^{offset[31:WORD_W+2], offset[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LOW;
      LOW:     if (cnt_last) state_nxt = HIGH;
      HIGH:    if (cnt_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      word_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            word_q  <= offset[2 +: WORD_W];
            wdata_q <= write_data;
            op_wr_q <= wr_en;
          end
        end
        LOW: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
          if (cnt_last && !op_wr_q) read_data[15:0] <= sram_dq_in;
        end
        HIGH: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
          if (cnt_last && !op_wr_q) read_data[31:16] <= sram_dq_in;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    ready       = ((state == IDLE) && !req) || (state == DONE);
    sram_addr   = {word_q, (state == HIGH)};
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'h0;
    if (state == LOW || state == HIGH) begin
      if (op_wr_q) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
      end else begin
        sram_oe_n   = 1'b0;
      end
    end
  end

  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: two instances (HALF_CYCLES 2 and 1) driving
// behavioural SRAMs, checked against a half-word reference memory.
module tb_sram_mem_controller;

  logic        clk;
  logic        rst [2];
  logic        rd_en [2];
  logic        wr_en [2];
  logic [31:0] address [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data [2];
  logic        ready [2];
  logic [17:0] sram_addr [2];
  logic [15:0] dq_out [2];
  logic [15:0] dq_in [2];
  logic        dq_oe [2];
  logic        we_n [2];
  logic        oe_n [2];
  logic        ce_n [2];
  logic        ub_n [2];
  logic        lb_n [2];

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  logic [15:0] ref_half [int];
  logic [31:0] last_rd [2];
  int          hc [2];
  int          vec;
  int          bad;

  sram_mem_controller #(.SRAM_AW(18), .BASE_ADDR(1024), .HALF_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
    .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]),
    .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]), .sram_we_n(we_n[0]),
    .sram_oe_n(oe_n[0]), .sram_ce_n(ce_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
  );

  sram_mem_controller #(.SRAM_AW(18), .BASE_ADDR(1024), .HALF_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
    .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]),
    .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]), .sram_we_n(we_n[1]),
    .sram_oe_n(oe_n[1]), .sram_ce_n(ce_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-write behavioural SRAMs
  always @(posedge clk) begin
    if (!we_n[0] && dq_oe[0]) mem0[sram_addr[0]] <= dq_out[0];
    if (!we_n[1] && dq_oe[1]) mem1[sram_addr[1]] <= dq_out[1];
  end
  assign dq_in[0] = oe_n[0] ? 16'h0 : mem0[sram_addr[0]];
  assign dq_in[1] = oe_n[1] ? 16'h0 : mem1[sram_addr[1]];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  function automatic logic [15:0] ref_get(input int i, input int idx);
    int key;
    key = i * 262144 + idx;
    return ref_half.exists(key) ? ref_half[key] : 16'h0;
  endfunction

  function automatic void ref_put(input int i, input int idx, input logic [15:0] v);
    ref_half[i * 262144 + idx] = v;
  endfunction

  function automatic logic [15:0] mem_get(input int i, input int idx);
    return (i == 0) ? mem0[idx] : mem1[idx];
  endfunction

  // One 32-bit transaction; keep leaves the request asserted for a back-to-back follow-up.
  task automatic txn(input int i, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input bit keep);
    int          w;
    int          lowc;
    bit          done;
    bit          half;
    logic [17:0] ea;
    logic [36:0] obs;
    logic [36:0] exp;
    @(posedge clk); #1;
    if (!rd_en[i] && !wr_en[i]) chk("idle_ready", 64'(ready[i]), 64'd1);
    rd_en[i] = rd; wr_en[i] = wr; address[i] = a; write_data[i] = d;
    w = word_of(a);
    #1;
    chk("ready_fall", 64'(ready[i]), 64'd0);
    lowc = 1;
    done = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk); #1;
      if (ready[i]) done = 1;
      else begin
        lowc++;
        half = (k > hc[i]);
        ea   = 18'(w * 2 + int'(half));
        obs  = {sram_addr[i], we_n[i], oe_n[i], dq_oe[i], wr ? dq_out[i] : 16'h0};
        exp  = {ea, !wr, wr, wr, wr ? (half ? d[31:16] : d[15:0]) : 16'h0};
        chk("pins", 64'(obs), 64'(exp));
      end
      address[i]    = $urandom;
      write_data[i] = $urandom;
    end
    chk("low_cycles", 64'(lowc), 64'(2 * hc[i] + 1));
    if (wr) begin
      ref_put(i, w * 2, d[15:0]);
      ref_put(i, w * 2 + 1, d[31:16]);
    end else begin
      last_rd[i] = {ref_get(i, w * 2 + 1), ref_get(i, w * 2)};
    end
    chk("read_data", 64'(read_data[i]), 64'(last_rd[i]));
    if (!keep) begin
      rd_en[i] = 1'b0;
      wr_en[i] = 1'b0;
    end
  endtask

  initial begin
    vec = 0;
    bad = 0;
    hc[0] = 2;
    hc[1] = 1;
    for (int i = 0; i < 262144; i++) begin
      mem0[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rd_en[i] = 1'b0; wr_en[i] = 1'b0;
      address[i] = 32'h0; write_data[i] = 32'h0; last_rd[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 64'(ready[i]), 64'd1);
      chk("rst_we_n", 64'(we_n[i]), 64'd1);
      chk("rst_dq_oe", 64'(dq_oe[i]), 64'd0);
      chk("rst_read_data", 64'(read_data[i]), 64'd0);
      chk("rst_sram_addr", 64'(sram_addr[i]), 64'd0);
    end

    // Directed write/read of 1028 on the two-cycle instance
    txn(0, 0, 1, 32'd1028, 32'hDEADBEEF, 0);
    chk("sram_lo", 64'(mem0[2]), 64'hBEEF);
    chk("sram_hi", 64'(mem0[3]), 64'hDEAD);
    txn(0, 1, 0, 32'd1028, 32'h0, 0);
    txn(0, 1, 1, 32'd1036, 32'h12345678, 0);
    chk("both_wr_lo", 64'(mem0[6]), 64'h5678);
    txn(0, 0, 1, 32'd1040, 32'hA5A5C3C3, 1);
    txn(0, 1, 0, 32'd1040, 32'h0, 1);
    txn(0, 1, 0, 32'd1036, 32'h0, 0);

    // Reset abandons a write at the LOW-to-HIGH boundary
    txn(0, 0, 1, 32'd1044, 32'h11112222, 0);
    @(posedge clk); #1;
    wr_en[0] = 1'b1; address[0] = 32'd1044; write_data[0] = 32'hAAAABBBB;
    repeat (hc[0]) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    wr_en[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("rst_mid_we_n", 64'(we_n[0]), 64'd1);
    chk("rst_mid_dq_oe", 64'(dq_oe[0]), 64'd0);
    chk("rst_mid_ready", 64'(ready[0]), 64'd1);
    chk("rst_mid_read_data", 64'(read_data[0]), 64'd0);
    @(posedge clk); #1;
    chk("rst_mid_hi_kept", 64'(mem0[11]), 64'h1111);
    ref_put(0, 10, 16'hBBBB);
    last_rd[0] = 32'h0;
    txn(0, 1, 0, 32'd1044, 32'h0, 0);

    // Single-cycle instance, including address wrap
    txn(1, 0, 1, 32'd1028, 32'hCAFEF00D, 0);
    txn(1, 1, 0, 32'd1028, 32'h0, 0);
    txn(1, 0, 1, 32'd1024 + (32'd4 << 17), 32'h0BADC0DE, 0);
    chk("wrap_lo", 64'(mem1[0]), 64'hC0DE);
    chk("wrap_hi", 64'(mem1[1]), 64'h0BAD);
    txn(1, 1, 0, 32'd1024, 32'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a;
        int          op;
        bit          kp;
        op = $urandom_range(0, 2);
        a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'd1024 + 32'($urandom_range(0, 63));
        kp = (n < 29) && ($urandom_range(0, 1) == 1);
        txn(i, op != 1, op != 0, a, $urandom, kp);
      end
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (k < 4) ? 2 * word_of(32'd1024 + 32'(4 * k)) : int'($urandom_range(0, 127));
        chk("sram_content", 64'(mem_get(i, idx)), 64'(ref_get(i, idx)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
